bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter and transfer sequencer for the shared 4-lane source/destination bus. Four requesters compete for one WIDTH-bit bus.
- The block grants one requester at a time and drives the source-select, destination-select and enable for the fixed transfer window.
- At the end of the window it captures the bus value into the selected destination's output register.
- It sits between the switch/button front end and the bus mux/demux pair, replacing direct button-driven selects with sequenced, fair access.

## Interface
Parameters:
- WIDTH, 4, bus and per-lane data width
- HOLD_CYCLES, 4, cycles the bus is held per transfer (>=1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per source lane 0..3; level-sensitive, held until done
- dest  input  8  destination code per requester; dest[2i+1:2i] belongs to requester i
- src_data  input  4*WIDTH  source lanes; lane i = src_data[WIDTH*i +: WIDTH]
- grant  output  4  one-hot grant; 0 when no transfer is active
- mux_sel  output  2  source select for the bus mux
- demux_sel  output  2  destination select for the bus demux
- bus_en  output  1  bus enable; high only in GRANT
- dst_data  output  4*WIDTH  destination registers; lane d = dst_data[WIDTH*d +: WIDTH]
- done  output  1  one-cycle pulse after a completed transfer
- busy  output  1  high in GRANT and RELEASE

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, pick the winner starting the search at pointer `ptr` and wrapping 3->0.
  - Register grant, mux_sel = winner index and demux_sel = dest field of the winner. dest is sampled once here and ignored for the rest of the transfer.
  - Load the hold counter with 0 and go to GRANT.
- GRANT:
  - bus_en=1. The counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1 and req[winner] is still 1:
    - dst_data lane demux_sel <= src_data lane mux_sel.
    - ptr <= winner+1 (mod 4).
    - Go to RELEASE with done pending.
  - If req[winner] drops before the final cycle, abort:
    - No capture and no done pulse.
    - ptr <= winner+1.
    - Go to IDLE; grant, bus_en and busy clear on the next edge.
- RELEASE:
  - One cycle. grant=0, bus_en=0, done=1, busy=1. Always go to IDLE.
  - This guarantees a 1-cycle dead gap between transfers.
- Only the captured destination lane changes. The other three lanes of dst_data hold their values.
- Two requesters with the same dest are serialised. The later transfer overwrites the lane.
- Requests arriving during GRANT/RELEASE are not seen until IDLE.
- Counter width is $clog2(HOLD_CYCLES) bits, minimum 1. With HOLD_CYCLES=1, GRANT lasts exactly one cycle.

## Timing
- Reset values (async assert, sync deassert handled upstream):
  - state=IDLE, ptr=0, grant=0, mux_sel=0, demux_sel=0.
  - bus_en=0, done=0, busy=0, dst_data=0.
- Request to grant: req high at edge N gives grant/bus_en high from N+1.
- A transfer occupies HOLD_CYCLES cycles in GRANT plus 1 in RELEASE.
- Minimum request-to-request spacing for back-to-back service is HOLD_CYCLES+2 cycles.
- Capture happens at the edge that ends the final GRANT cycle. dst_data is valid in the same cycle done=1.
- All outputs are registered; there is no combinational path from req to grant.
- Reset mid-transfer: all outputs go to reset values immediately. The partial transfer is lost and dst_data clears.

## Configuration
- BUS_ARB_FIXED_PRI_EN defined: fixed priority, req[0] highest, req[3] lowest. ptr is not used, and its register may be optimised away.
- BUS_ARB_FIXED_PRI_EN undefined (default): round-robin as described above.

## Test plan
1. Reset, then req=4'b0100, dest[5:4]=2'd3, lane2=4'hA:
   - grant=4'b0100, mux_sel=2, demux_sel=3 for 4 cycles.
   - Then done=1 with dst_data lane3=4'hA and all other lanes 0.
2. req=4'b1111 held, all dest=0, lanes 1,2,3,4 (lane0=1 … lane3=4):
   - Grants in order 0,1,2,3,0.
   - done pulses 6 cycles apart; dst lane0 sequence 1,2,3,4.
3. Abort: grant lane1, drop req[1] on the 2nd GRANT cycle:
   - No done and dst_data unchanged.
   - Next grant goes to lane2 when both req[1] and req[2] are raised.
4. Reset asserted in the 3rd GRANT cycle:
   - grant, bus_en, busy and dst_data go to 0 asynchronously.
   - After release, req=4'b0001 is granted lane0 (ptr=0).
5. Change dest during GRANT from 1 to 2: demux_sel stays 1 and capture lands in lane1.
6. With BUS_ARB_FIXED_PRI_EN, req=4'b1010 held: lane1 is granted every time and lane3 is never granted.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter and transfer sequencer for a shared
//               4-lane source/destination bus. Grants one requester at a time,
//               holds the bus for HOLD_CYCLES cycles, then captures the bus
//               value into the selected destination register.
//               Define BUS_ARB_FIXED_PRI_EN for fixed priority (req[0] highest)
//               instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [7:0]           dest,
  input  logic [4*WIDTH-1:0]   src_data,
  output logic [3:0]           grant,
  output logic [1:0]           mux_sel,
  output logic [1:0]           demux_sel,
  output logic                 bus_en,
  output logic [4*WIDTH-1:0]   dst_data,
  output logic                 done,
  output logic                 busy
);

  localparam int c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_grant;
  logic [1:0]           r_mux;
  logic [1:0]           r_demux;
  logic [1:0]           r_ptr;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_bus_en;
  logic                 r_done;
  logic                 r_busy;
  logic [4*WIDTH-1:0]   r_dst;

  state_t               w_state_nxt;
  logic [3:0]           w_grant_nxt;
  logic [1:0]           w_mux_nxt;
  logic [1:0]           w_demux_nxt;
  logic [1:0]           w_ptr_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_bus_en_nxt;
  logic                 w_done_nxt;
  logic                 w_busy_nxt;
  logic                 w_capture;
  logic [1:0]           w_win;

  // Winner search: the lowest search offset that has a request wins
  always_comb begin
    w_win = 2'd0;
`ifdef BUS_ARB_FIXED_PRI_EN
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) w_win = 2'(k);
    end
`else
    for (int k = 3; k >= 0; k--) begin
      logic [1:0] w_idx;
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) w_win = w_idx;
    end
`endif
  end

  // Next-state and next-output decode; every output is registered
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = 4'b0000;
    w_mux_nxt    = r_mux;
    w_demux_nxt  = r_demux;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_bus_en_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          // dest is sampled only here; later changes are ignored
          w_state_nxt  = S_GRANT;
          w_grant_nxt  = 4'b0001 << w_win;
          w_mux_nxt    = w_win;
          w_demux_nxt  = dest[2*w_win +: 2];
          w_cnt_nxt    = '0;
          w_bus_en_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
        end
      end
      S_GRANT: begin
        if (!req[r_mux]) begin
          // Requester gave up: abandon the transfer, still advance fairness
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_mux + 2'd1;
        end else if (r_cnt == c_CNT_LAST) begin
          w_capture   = 1'b1;
          w_ptr_nxt   = r_mux + 2'd1;
          w_state_nxt = S_RELEASE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + 1'b1;
          w_grant_nxt  = r_grant;
          w_bus_en_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
        end
      end
      S_RELEASE: begin
        // Dead cycle between transfers
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, output and destination registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= 4'b0000;
      r_mux    <= 2'd0;
      r_demux  <= 2'd0;
      r_ptr    <= 2'd0;
      r_cnt    <= '0;
      r_bus_en <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_dst    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_mux    <= w_mux_nxt;
      r_demux  <= w_demux_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bus_en <= w_bus_en_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      if (w_capture) begin
        r_dst[WIDTH*r_demux +: WIDTH] <= src_data[WIDTH*r_mux +: WIDTH];
      end
    end
  end

  assign grant     = r_grant;
  assign mux_sel   = r_mux;
  assign demux_sel = r_demux;
  assign bus_en    = r_bus_en;
  assign done      = r_done;
  assign busy      = r_busy;
  assign dst_data  = r_dst;

endmodule
`default_nettype wire
